// File: rtl/mod_mul_arbiter.sv
// ============================================================================
// Module   : mod_mul_arbiter
// Brief    : Round-robin scheduler that shares one interleaved modular
//            multiplier among NREQ requesters. Jobs (a, b, m) are accepted
//            over valid/ready, launched with a one-cycle start pulse, and the
//            product is returned with the requester index on a single
//            backpressured response port.
// Options  : MOD_MUL_ARB_WATCHDOG_EN - when defined, a WAIT-state watchdog
//            aborts a job after TIMEOUT cycles and reports rsp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_mul_arbiter #(
    parameter int NBITS   = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*NBITS-1:0]      req_a,
    input  logic [NREQ*NBITS-1:0]      req_b,
    input  logic [NREQ*NBITS-1:0]      req_m,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [NBITS-1:0]           rsp_y,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       rsp_err,

    output logic                       busy,

    output logic                       mm_enable_p,
    output logic [NBITS-1:0]           mm_a,
    output logic [NBITS-1:0]           mm_b,
    output logic [NBITS-1:0]           mm_m,
    input  logic [NBITS-1:0]           mm_y,
    input  logic                       mm_done_irq_p
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [IDW:0] c_nreq = (IDW+1)'(NREQ);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   r_cur_id;
    logic [IDW-1:0]   w_grant_idx;
    logic             w_hit;

    logic [NBITS-1:0] w_sel_a;
    logic [NBITS-1:0] w_sel_b;
    logic [NBITS-1:0] w_sel_m;

    logic [NBITS-1:0] r_mm_a;
    logic [NBITS-1:0] r_mm_b;
    logic [NBITS-1:0] r_mm_m;
    logic [NBITS-1:0] r_rsp_y;
    logic             r_rsp_err;

    logic             w_wd_expire;

    // Round-robin search: first valid requester at or after last_grant+1, wrapping.
    always_comb begin
        logic [IDW:0] v_sum;
        w_hit       = 1'b0;
        w_grant_idx = '0;
        v_sum       = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_sum = {1'b0, r_last_grant} + (IDW+1)'(i + 1);
            if (v_sum >= c_nreq) begin
                v_sum = v_sum - c_nreq;
            end
            if (!w_hit && req_valid[v_sum[IDW-1:0]]) begin
                w_hit       = 1'b1;
                w_grant_idx = v_sum[IDW-1:0];
            end
        end
    end

    // Operand mux selecting the winning requester's slice.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_m = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_grant_idx) begin
                w_sel_a = req_a[i*NBITS +: NBITS];
                w_sel_b = req_b[i*NBITS +: NBITS];
                w_sel_m = req_m[i*NBITS +: NBITS];
            end
        end
    end

`ifdef MOD_MUL_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] r_wd_cnt;

    // Watchdog counter: cleared on the way into WAIT, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Expiry on the TIMEOUT-th WAIT cycle; the next state is then RESP.
    assign w_wd_expire = (r_wd_cnt == WDW'(TIMEOUT - 1));
`else
    // No watchdog: WAIT only ends on a done pulse (constant-false term).
    assign w_wd_expire = (TIMEOUT < 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_hit) w_next_state = S_LAUNCH;
            S_LAUNCH: w_next_state = S_WAIT;
            S_WAIT:   if (mm_done_irq_p || w_wd_expire) w_next_state = S_RESP;
            S_RESP:   if (rsp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs; req_ready is only ever raised in IDLE.
    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_hit) begin
            req_ready[w_grant_idx] = 1'b1;
        end
        mm_enable_p = (r_state == S_LAUNCH);
        busy        = (r_state != S_IDLE);
        rsp_valid   = (r_state == S_RESP);
    end

    // Job capture at grant; operands stay put until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mm_a       <= '0;
            r_mm_b       <= '0;
            r_mm_m       <= '0;
            r_cur_id     <= '0;
            r_last_grant <= IDW'(NREQ - 1);
        end else if (r_state == S_IDLE && w_hit) begin
            r_mm_a       <= w_sel_a;
            r_mm_b       <= w_sel_b;
            r_mm_m       <= w_sel_m;
            r_cur_id     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
        end
    end

    // Result capture; a done pulse outside WAIT never reaches these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_y   <= '0;
            r_rsp_err <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (mm_done_irq_p) begin
                r_rsp_y   <= mm_y;
                r_rsp_err <= 1'b0;
            end else if (w_wd_expire) begin
                r_rsp_y   <= '0;
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign mm_a    = r_mm_a;
    assign mm_b    = r_mm_b;
    assign mm_m    = r_mm_m;
    assign rsp_y   = r_rsp_y;
    assign rsp_id  = r_cur_id;
    assign rsp_err = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_mod_mul_arbiter.sv
// ============================================================================
// Module   : tb_mod_mul_arbiter
// Brief    : Self-checking bench for mod_mul_arbiter (NBITS=8, NREQ=4,
//            TIMEOUT=16). A behavioural multiplier stub answers launches and
//            injects stray done pulses; a grant checker predicts round-robin
//            winners and queues expected responses; a response monitor pops
//            and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_mul_arbiter;

    localparam int NB = 8;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*NB-1:0]  req_a, req_b, req_m;
    logic              rsp_valid, rsp_ready;
    logic [NB-1:0]     rsp_y;
    logic [1:0]        rsp_id;
    logic              rsp_err, busy, mm_enable_p;
    logic [NB-1:0]     mm_a, mm_b, mm_m, mm_y;
    logic              mm_done_irq_p;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_q[$];
    int   grant_cnt = 0;
    int   hs_cnt    = 0;
    int   m_last    = NR - 1;

    int   rdy_mode  = 2;
    bit   rand_en   = 0;
    bit   stray_en  = 1;
    bit   lat_slow  = 0;
    bit   no_done   = 0;
    bit   exp_to    = 0;

    mod_mul_arbiter #(.NBITS(NB), .NREQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_m(req_m),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy), .mm_enable_p(mm_enable_p),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_y(mm_y), .mm_done_irq_p(mm_done_irq_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Winner = first valid index strictly after the previous winner, cyclically.
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int d = 1; d <= NR; d++) begin
            if (v[(last + d) % NR]) return (last + d) % NR;
        end
        return -1;
    endfunction

    task automatic drive_job(input int i, input int a, input int b, input int m);
        req_a[i*NB +: NB] = NB'(a);
        req_b[i*NB +: NB] = NB'(b);
        req_m[i*NB +: NB] = NB'(m);
        req_valid[i]      = 1'b1;
    endtask

    task automatic rand_job(input int i);
        int m;
        m = $urandom_range(1, 255);
        drive_job(i, $urandom_range(0, m - 1), $urandom_range(0, m - 1), m);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_enable"},    32'(mm_enable_p), 0);
        chk({tag, "_mm_abm"},    {8'd0, mm_a, mm_b, mm_m}, 0);
        chk({tag, "_rsp_y"},     32'(rsp_y), 0);
        chk({tag, "_rsp_id"},    32'(rsp_id), 0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #2;
            if (grant_cnt == hs_cnt && exp_q.size() == 0 && !busy) ok = 1;
        end
        chk({name, "_drain"}, 32'(ok), 1);
    endtask

    // Multiplier stub: answers each launch after a random latency with
    // a*b mod m; when idle it may fire a stray done pulse with junk data.
    always begin
        int  cnt;
        int  res;
        bit  active;
        bit  prev_en;
        @(negedge clk);
        mm_done_irq_p = 1'b0;
        if (!rst_n) begin
            active = 0;
        end else begin
            if (mm_enable_p) begin
                n_tests++;
                if (prev_en) begin
                    n_fail++;
                    $display("FAIL enable_pulse: mm_enable_p high 2 cycles, expected 1");
                end
            end
            if (active) begin
                if (cnt <= 1) begin
                    mm_done_irq_p = 1'b1;
                    mm_y          = NB'(res);
                    active        = 0;
                end else begin
                    cnt--;
                end
            end else if (stray_en && !no_done && $urandom_range(0, 3) == 0) begin
                mm_done_irq_p = 1'b1;
                mm_y          = NB'($urandom);
            end
            if (mm_enable_p) begin
                active = !no_done;
                cnt    = lat_slow ? 30 : $urandom_range(1, 6);
                res    = (mm_m == 0) ? 0 : (int'(mm_a) * int'(mm_b)) % int'(mm_m);
            end
        end
        prev_en = mm_enable_p;
    end

    // Grant checker: predicts the winner whenever the arbiter has no job
    // outstanding, and queues that job's expected response.
    always begin
        int ek, ea, eb, em, ey;
        logic [NR-1:0] exp_vec;
        @(negedge clk); #1;
        if (!rst_n) begin
            m_last = NR - 1;
            grant_cnt <= hs_cnt;
        end else begin
            ek      = rr_pick(req_valid, m_last);
            exp_vec = '0;
            if (grant_cnt == hs_cnt && ek >= 0) exp_vec[ek] = 1'b1;
            if (req_ready != '0 || exp_vec != '0) begin
                n_tests++;
                if (req_ready !== exp_vec) begin
                    n_fail++;
                    $display("FAIL grant: req_ready=%b, expected %b", req_ready, exp_vec);
                end
            end
            if (exp_vec != '0) begin
                ea = int'(req_a[ek*NB +: NB]);
                eb = int'(req_b[ek*NB +: NB]);
                em = int'(req_m[ek*NB +: NB]);
                ey = exp_to ? 0 : (ea * eb) % em;
                exp_q.push_back({NB'(ey), 2'(ek), exp_to});
                m_last = ek;
                grant_cnt <= grant_cnt + 1;
            end
        end
    end

    // Response monitor: drives rsp_ready and compares every presented response.
    always begin
        @(negedge clk);
        case (rdy_mode)
            0:       rsp_ready = 1'($urandom_range(0, 1));
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
        #1;
        if (!rst_n) begin
            exp_q.delete();
        end else if (rsp_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: y=%0d id=%0d err=%0d, expected no response",
                         rsp_y, rsp_id, rsp_err);
            end else if ({rsp_y, rsp_id, rsp_err} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL rsp: y=%0d id=%0d err=%0d, expected y=%0d id=%0d err=%0d",
                         rsp_y, rsp_id, rsp_err, exp_q[0][10:3], exp_q[0][2:1], exp_q[0][0]);
            end
            if (rsp_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                hs_cnt <= hs_cnt + 1;
            end
        end
    end

    // Random requester driver: holds each job until accepted, then either
    // issues a new one or goes quiet; occasionally withdraws before a grant.
    always begin
        logic [NR-1:0] acc;
        @(negedge clk);
        if (rand_en) begin
            for (int i = 0; i < NR; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) rand_job(i);
                    else req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        #1;
        acc = req_ready;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NB-1:0] y0;
        int            g0;
        int            nw;
        bit            seen;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_m = '0;
        rsp_ready = 1'b0; mm_y = '0; mm_done_irq_p = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2 check_reset_vals("reset");

        // Single job from requester 1: 7*9 mod 13 = 11.
        @(negedge clk);
        drive_job(1, 7, 9, 13);
        #2 chk("t1_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        #2 chk("t1_launch", 32'(mm_enable_p), 1);
        chk("t1_ops", {8'd0, mm_a, mm_b, mm_m}, {8'd0, 8'd7, 8'd9, 8'd13});
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk); #2 chk("t1_one_pulse", 32'(mm_enable_p), 0);
        wait_drain("t1", 60);

        // Requesters 0 and 2 continuously valid from reset: order 0,2,0,2.
        do_reset();
        drive_job(0, 5, 6, 13);
        drive_job(2, 5, 6, 13);
        g0 = grant_cnt;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #2;
            if (grant_cnt == g0 + 4) seen = 1;
        end
        chk("t2_four_grants", 32'(seen), 1);
        @(negedge clk);
        req_valid = '0;
        wait_drain("t2", 60);

        // Backpressure: hold rsp_ready low while requester 0 waits.
        rdy_mode = 1;
        @(negedge clk);
        drive_job(3, 11, 10, 17);
        @(negedge clk);
        req_valid[3] = 1'b0;
        drive_job(0, 2, 3, 5);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk); #2;
            if (rsp_valid) seen = 1;
        end
        chk("t3_rsp_seen", 32'(seen), 1);
        y0 = rsp_y;
        chk("t3_y", 32'(y0), (11 * 10) % 17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("t3_hold", {28'd0, busy, rsp_valid, rsp_id}, {28'd0, 1'b1, 1'b1, 2'd3});
            chk("t3_y_stable", 32'(rsp_y), 32'(y0));
            chk("t3_no_ready", 32'(req_ready), 0);
        end
        rdy_mode = 2;
        @(negedge clk); #2 chk("t3_hs_cycle_ready", 32'(req_ready), 0);
        @(negedge clk); #2 chk("t3_next_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        rdy_mode = 0;
        wait_drain("t3", 60);

        // Reset while waiting on the multiplier; then 12*12 mod 13 = 1.
        lat_slow = 1;
        @(negedge clk);
        drive_job(2, 3, 4, 11);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #2;
        chk("t4_in_wait", {30'd0, busy, mm_enable_p}, {30'd0, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1 check_reset_vals("t4_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat_slow = 0;
        @(negedge clk);
        drive_job(0, 12, 12, 13);
        @(negedge clk);
        req_valid = '0;
        wait_drain("t4", 60);

        // Randomized traffic with random backpressure and stray done pulses.
        rand_en = 1;
        repeat (500) @(negedge clk);
        @(posedge clk);
        rand_en = 0;
        @(negedge clk);
        req_valid = '0;
        wait_drain("rand", 300);

        // Multiplier that never answers.
        no_done = 1;
`ifdef MOD_MUL_ARB_WATCHDOG_EN
        exp_to = 1;
`endif
        @(negedge clk);
        drive_job(1, 3, 5, 7);
        @(negedge clk);
        req_valid = '0;
`ifdef MOD_MUL_ARB_WATCHDOG_EN
        nw = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #2;
            if (rsp_valid) seen = 1;
            else nw++;
        end
        chk("wd_wait_cycles", 32'(nw), TO);
        wait_drain("wd", 60);
`else
        nw = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (busy && !rsp_valid) nw++;
        end
        chk("hang_busy_cycles", 32'(nw), 60);
        do_reset();
`endif
        no_done = 0;
        exp_to = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
